// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding control for a 5-stage RV32I pipeline.
// Tracks {rd, op class} of the instructions in EX and MEM, derives load-use
// stalls, branch flushes, forwarding selects and a saturating stall counter.
module hazard_fwd_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   input  logic [4:0]       rd_addr,
   input  logic             rs1use,
   input  logic             rs2use,
   input  logic [1:0]       hazard_optype,
   input  logic             branch_taken,
   output logic             PC_EN_IF,
   output logic             reg_FD_EN,
   output logic             reg_FD_flush,
   output logic             reg_DE_flush,
   output logic [1:0]       forward_ctrl_A,
   output logic [1:0]       forward_ctrl_B,
   output logic             forward_ctrl_ls,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_ALU   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_STORE = 2'b11
   } optype_t;

   typedef enum logic [1:0] {
      FWD_RF      = 2'b00,
      FWD_EX_ALU  = 2'b01,
      FWD_MEM_ALU = 2'b10,
      FWD_MEM_LD  = 2'b11
   } fwd_t;

   // The WB stage is not stored: the register file resolves WB-to-ID reads
   // by writing in the first half-cycle, so nothing downstream consumes it.
   logic [4:0] rd_ex, rd_mem;
   optype_t    op_ex, op_mem;
   logic       ls_ex, ls_mem;

   optype_t    op_id;
   logic       ld_m1, ld_m2;
   logic       load_use;
   logic       sal_id;
   fwd_t       fwd_a, fwd_b;

   assign op_id = optype_t'(hazard_optype);

   function automatic logic writes(input optype_t op);
      return (op == OP_ALU) || (op == OP_LOAD);
   endfunction

   // Nearest stage wins; a load in EX blocks forwarding from MEM because
   // that case is either stalled or handled by the store-data path.
   function automatic fwd_t fwd_sel(input logic [4:0] rs, input logic use_rs,
                                    input logic [4:0] r_ex, input optype_t o_ex,
                                    input logic [4:0] r_mem, input optype_t o_mem);
      fwd_t sel;
      sel = FWD_RF;
      if (use_rs && (rs != 5'd0)) begin
         if ((rs == r_ex) && writes(o_ex)) begin
            sel = (o_ex == OP_ALU) ? FWD_EX_ALU : FWD_RF;
         end else if ((rs == r_mem) && writes(o_mem)) begin
            sel = (o_mem == OP_ALU) ? FWD_MEM_ALU : FWD_MEM_LD;
         end
      end
      return sel;
   endfunction

   // Load-use detection with the store-data exception.
   always_comb begin
      ld_m1    = (op_ex == OP_LOAD) && (rd_ex != 5'd0) && rs1use && (rs1_addr == rd_ex);
      ld_m2    = (op_ex == OP_LOAD) && (rd_ex != 5'd0) && rs2use && (rs2_addr == rd_ex);
      sal_id   = (op_id == OP_STORE) && ld_m2 && !ld_m1;
      load_use = (ld_m1 || ld_m2) && !sal_id && rst;
      fwd_a    = fwd_sel(rs1_addr, rs1use, rd_ex, op_ex, rd_mem, op_mem);
      fwd_b    = fwd_sel(rs2_addr, rs2use, rd_ex, op_ex, rd_mem, op_mem);
   end

   // Pipeline control and forwarding outputs, held at idle values during reset.
   always_comb begin
      PC_EN_IF        = 1'b1;
      reg_FD_EN       = 1'b1;
      reg_FD_flush    = 1'b0;
      reg_DE_flush    = 1'b0;
      forward_ctrl_A  = FWD_RF;
      forward_ctrl_B  = FWD_RF;
      forward_ctrl_ls = 1'b0;
      if (rst) begin
         PC_EN_IF        = !load_use;
         reg_FD_EN       = !load_use;
         reg_DE_flush    = load_use;
         reg_FD_flush    = branch_taken && !load_use;
         forward_ctrl_A  = fwd_a;
         forward_ctrl_B  = fwd_b;
         forward_ctrl_ls = ls_mem;
      end
   end

   // Stage tracking: ID->EX (bubble on stall), EX->MEM.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ex  <= '0;
         op_ex  <= OP_NONE;
         ls_ex  <= 1'b0;
         rd_mem <= '0;
         op_mem <= OP_NONE;
         ls_mem <= 1'b0;
      end else begin
         rd_mem <= rd_ex;
         op_mem <= op_ex;
         ls_mem <= ls_ex;
         if (load_use) begin
            rd_ex <= '0;
            op_ex <= OP_NONE;
            ls_ex <= 1'b0;
         end else begin
            rd_ex <= rd_addr;
            op_ex <= op_id;
            ls_ex <= sal_id;
         end
      end
   end

   // Saturating count of load-use stall cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (load_use && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios with literal
// expectations, then randomized traffic checked against a pipeline model.
module tb_hazard_fwd_unit;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    rs1_addr, rs2_addr, rd_addr;
   logic          rs1use, rs2use, branch_taken;
   logic [1:0]    hazard_optype;
   logic          PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_ls;
   logic [1:0]    forward_ctrl_A, forward_ctrl_B;
   logic [CW-1:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   // Model: index 0 = EX, 1 = MEM, 2 = WB.
   int m_rd[3]  = '{0, 0, 0};
   int m_op[3]  = '{0, 0, 0};
   bit m_sal[3] = '{0, 0, 0};
   int m_cnt    = 0;
   bit started  = 0;

   always #5 clk = ~clk;

   hazard_fwd_unit #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1use(rs1use), .rs2use(rs2use), .hazard_optype(hazard_optype),
      .branch_taken(branch_taken),
      .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
      .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
      .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
      .forward_ctrl_ls(forward_ctrl_ls), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_writer(input int op);
      return (op == 1) || (op == 2);
   endfunction

   // True when the ID operand names the destination of the load sitting in EX.
   function automatic bit load_hit(input int rs, input bit u);
      return u && (m_op[0] == 2) && (m_rd[0] != 0) && (rs == m_rd[0]);
   endfunction

   function automatic bit m_sal_id();
      return (hazard_optype == 2'b11) && load_hit(int'(rs2_addr), rs2use)
             && !load_hit(int'(rs1_addr), rs1use);
   endfunction

   function automatic bit m_stall();
      return (load_hit(int'(rs1_addr), rs1use) || load_hit(int'(rs2_addr), rs2use))
             && !m_sal_id();
   endfunction

   function automatic int m_fwd(input int rs, input bit u);
      if (!u || rs == 0) return 0;
      if (m_rd[0] == rs && is_writer(m_op[0])) return (m_op[0] == 1) ? 1 : 0;
      if (m_rd[1] == rs && is_writer(m_op[1])) return (m_op[1] == 1) ? 2 : 3;
      return 0;
   endfunction

   // Model advance on every clock edge.
   always @(posedge clk) begin
      bit hz, sal;
      if (!rst) begin
         m_rd  = '{0, 0, 0};
         m_op  = '{0, 0, 0};
         m_sal = '{0, 0, 0};
         m_cnt = 0;
         started = 1;
      end else begin
         hz  = m_stall();
         sal = m_sal_id();
         for (int i = 2; i > 0; i--) begin
            m_rd[i]  = m_rd[i-1];
            m_op[i]  = m_op[i-1];
            m_sal[i] = m_sal[i-1];
         end
         m_rd[0]  = hz ? 0 : int'(rd_addr);
         m_op[0]  = hz ? 0 : int'(hazard_optype);
         m_sal[0] = !hz && sal;
         if (hz && m_cnt < CMAX) m_cnt++;
      end
   end

   // Compare every cycle, mid-period.
   always @(negedge clk) begin
      bit hz;
      if (started) begin
         hz = rst && m_stall();
         chk("pc_en",    PC_EN_IF,        !hz);
         chk("fd_en",    reg_FD_EN,       !hz);
         chk("de_flush", reg_DE_flush,    hz);
         chk("fd_flush", reg_FD_flush,    rst && branch_taken && !hz);
         chk("fwd_a",    forward_ctrl_A,  rst ? m_fwd(int'(rs1_addr), rs1use) : 0);
         chk("fwd_b",    forward_ctrl_B,  rst ? m_fwd(int'(rs2_addr), rs2use) : 0);
         chk("fwd_ls",   forward_ctrl_ls, rst && m_sal[1]);
         chk("cnt",      stall_cnt,       m_cnt);
      end
   end

   task automatic set_in(input int r1, input int r2, input int rd, input bit u1,
                         input bit u2, input int op, input bit br);
      rs1_addr = 5'(r1); rs2_addr = 5'(r2); rd_addr = 5'(rd);
      rs1use = u1; rs2use = u2; hazard_optype = 2'(op); branch_taken = br;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
      rs1use = 1'b0; rs2use = 1'b0; hazard_optype = '0; branch_taken = 1'b0;
      tick(); tick();
      // During reset: idle outputs even with a taken branch and operands in use
      set_in(5, 5, 6, 1, 1, 1, 1);
      chk("rst_pc", PC_EN_IF, 1); chk("rst_flush", reg_FD_flush, 0);
      chk("rst_cnt", stall_cnt, 0); chk("rst_fa", forward_ctrl_A, 0);
      tick();
      rst = 1'b1;
      set_in(1, 2, 5, 1, 1, 1, 0); chk("alu0_fa", forward_ctrl_A, 0); tick();
      set_in(5, 5, 6, 1, 1, 1, 0); chk("alu_ex_a", forward_ctrl_A, 1);
      chk("alu_ex_b", forward_ctrl_B, 1); chk("alu_ex_pc", PC_EN_IF, 1); tick();
      set_in(5, 5, 8, 1, 1, 1, 0); chk("alu_mem_a", forward_ctrl_A, 2);
      chk("alu_mem_b", forward_ctrl_B, 2); tick();
      // Load-use
      set_in(1, 0, 7, 1, 0, 2, 0); tick();
      set_in(7, 1, 8, 1, 1, 1, 0); chk("lu_pc", PC_EN_IF, 0); chk("lu_fd", reg_FD_EN, 0);
      chk("lu_de", reg_DE_flush, 1); chk("lu_cnt0", stall_cnt, 0); tick();
      set_in(7, 1, 8, 1, 1, 1, 0); chk("lu_ld_a", forward_ctrl_A, 3);
      chk("lu_pc2", PC_EN_IF, 1); chk("lu_cnt1", stall_cnt, 1); tick();
      // Store-after-load: sw x9,0(x2)
      set_in(1, 0, 9, 1, 0, 2, 0); tick();
      set_in(2, 9, 0, 1, 1, 3, 0); chk("sal_pc", PC_EN_IF, 1); chk("sal_de", reg_DE_flush, 0);
      chk("sal_b", forward_ctrl_B, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); chk("sal_ls0", forward_ctrl_ls, 0); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); chk("sal_ls1", forward_ctrl_ls, 1); tick();
      // sw x2,0(x9): base depends on load
      set_in(1, 0, 9, 1, 0, 2, 0); tick();
      set_in(9, 2, 0, 1, 1, 3, 0); chk("sab_pc", PC_EN_IF, 0); chk("sab_de", reg_DE_flush, 1); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); chk("sab_cnt", stall_cnt, 2); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); chk("sab_ls", forward_ctrl_ls, 0); tick();
      // x0 destinations
      set_in(1, 0, 0, 1, 0, 1, 0); tick();
      set_in(0, 0, 1, 1, 1, 1, 0); chk("x0_fa", forward_ctrl_A, 0); chk("x0_fb", forward_ctrl_B, 0); tick();
      set_in(1, 0, 0, 1, 0, 2, 0); tick();
      set_in(0, 0, 2, 1, 0, 1, 0); chk("x0_ld_pc", PC_EN_IF, 1); chk("x0_ld_de", reg_DE_flush, 0); tick();
      // Branches
      set_in(0, 0, 0, 0, 0, 0, 1); chk("br_flush", reg_FD_flush, 1); chk("br_pc", PC_EN_IF, 1); tick();
      set_in(1, 0, 3, 1, 0, 2, 0); tick();
      set_in(3, 0, 4, 1, 0, 1, 1); chk("brlu_flush", reg_FD_flush, 0); chk("brlu_pc", PC_EN_IF, 0);
      chk("brlu_cnt", stall_cnt, 2); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); chk("sat_cnt3", stall_cnt, 3); tick();
      set_in(1, 0, 3, 1, 0, 2, 0); tick();
      set_in(3, 0, 4, 1, 0, 1, 0); chk("sat_stall", reg_DE_flush, 1); tick();
      set_in(0, 0, 0, 0, 0, 0, 0); chk("sat_hold", stall_cnt, 3); tick();
      // Reset in the middle of a stall
      set_in(1, 0, 3, 1, 0, 2, 0); tick();
      rst = 1'b0;
      set_in(3, 0, 4, 1, 0, 1, 0); chk("rstm_pc", PC_EN_IF, 1); chk("rstm_de", reg_DE_flush, 0); tick();
      rst = 1'b1;
      set_in(3, 0, 4, 1, 0, 1, 0); chk("rstm_after_pc", PC_EN_IF, 1); chk("rstm_after_de", reg_DE_flush, 0);
      chk("rstm_cnt", stall_cnt, 0); chk("rstm_fa", forward_ctrl_A, 0); tick();
      // Randomized traffic, small register set to provoke dependencies
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 59) != 0);
         rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
         rd_addr = 5'($urandom_range(0, 3));
         rs1use = 1'($urandom); rs2use = 1'($urandom);
         hazard_optype = 2'($urandom); branch_taken = ($urandom_range(0, 5) == 0);
         tick();
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
